// File: rtl/str_rr_merge_if.sv
// str_rr_merge_if: upstream and downstream stream bundle for the round-robin merger.
interface str_rr_merge_if #(
   parameter int US = 2,
   parameter int DW = 16
);
   localparam int IW = $clog2(US);
   logic signed [DW-1:0] idata [US];
   logic [US-1:0] ilast, ivalid, iready;
   logic signed [DW-1:0] odata;
   logic [IW-1:0] oid;
   logic olast, ovalid, oready;
   modport master (output idata, ilast, ivalid, oready, input iready, odata, oid, olast, ovalid);
   modport slave (input idata, ilast, ivalid, oready, output iready, odata, oid, olast, ovalid);
endinterface

// File: rtl/str_rr_merge.sv
// str_rr_merge: packet-atomic round-robin merge of US streams into one,
// driving the downstream through a single forward register.
module str_rr_merge #(
   parameter int US = 2,
   parameter int DW = 16
) (
   input logic clk,
   input logic rst,
   str_rr_merge_if.slave bus
);
   localparam int IW = $clog2(US);
   typedef enum logic {IDLE, LOCK} state_t;
   state_t state, state_n;
   logic [IW-1:0] g, g_n, ptr, ptr_n, sel, cur;
   logic ofree, xfer, cur_last;
   // downward scan so the lowest offset from ptr wins
   always_comb begin
      sel = ptr;
      for (int k = US - 1; k >= 0; k--)
         if (bus.ivalid[IW'((int'(ptr) + k) % US)]) sel = IW'((int'(ptr) + k) % US);
   end
   assign ofree = ~bus.ovalid | bus.oready;
   assign cur = (state == LOCK) ? g : sel;
   assign cur_last = bus.ilast[cur];
   assign xfer = |(bus.iready & bus.ivalid);
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         state <= IDLE;
         g <= '0;
         ptr <= '0;
      end else begin
         state <= state_n;
         g <= g_n;
         ptr <= ptr_n;
      end
   always_comb begin
      state_n = state;
      g_n = g;
      ptr_n = ptr;
      if (xfer) begin
         state_n = cur_last ? IDLE : LOCK;
         if (state == IDLE && !cur_last) g_n = sel;
         if (cur_last) ptr_n = IW'((int'(cur) + 1) % US);
      end
   end
   always_comb begin
      bus.iready = '0;
      if (rst && ofree && (state == LOCK || |bus.ivalid)) bus.iready[cur] = 1'b1;
   end
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         bus.ovalid <= 1'b0;
         bus.olast <= 1'b0;
         bus.odata <= '0;
         bus.oid <= '0;
      end else if (xfer) begin
         bus.ovalid <= 1'b1;
         bus.olast <= cur_last;
         bus.odata <= bus.idata[cur];
         bus.oid <= cur;
      end else if (bus.oready) bus.ovalid <= 1'b0;
endmodule

// File: tb/tb_str_rr_merge.sv
// tb_str_rr_merge: directed and randomized checks of str_rr_merge against a
// cycle-level reference model plus per-channel ordering scoreboard.
module tb_str_rr_merge;
   localparam int US = 4;
   localparam int DW = 16;
   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;
   str_rr_merge_if #(.US(US), .DW(DW)) bus ();
   str_rr_merge #(.US(US), .DW(DW)) dut (.clk(clk), .rst(rst), .bus(bus));
   int n_cmp = 0;
   int n_bad = 0;
   logic m_ov, m_last;
   logic [DW-1:0] m_data;
   int m_id, m_owner, m_ptr;
   logic [US-1:0] acc;
   int wt [US];
   int seq [US];
   logic [DW:0] pend [US][$];
   logic [DW:0] sent [US][$];
   int olog [$];
   logic out_mid;
   int out_id;

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic exp_log(string nm, int k, int v);
      if (k < olog.size()) chk(nm, olog[k], v);
      else begin
         n_cmp++;
         n_bad++;
         $display("FAIL %s: beat %0d missing, expected %0h", nm, k, v);
      end
   endtask

   task automatic push(int ch, logic [DW-1:0] d, logic l);
      pend[ch].push_back({l, d});
      sent[ch].push_back({l, d});
   endtask

   // grant the rules imply for the inputs now on the bus
   function automatic logic [US-1:0] exp_rdy();
      logic [US-1:0] r;
      r = '0;
      if (!rst || (m_ov && !bus.oready)) return r;
      if (m_owner >= 0) begin
         r[m_owner] = 1'b1;
         return r;
      end
      for (int k = 0; k < US; k++)
         if (bus.ivalid[(m_ptr + k) % US]) begin
            r[(m_ptr + k) % US] = 1'b1;
            return r;
         end
      return r;
   endfunction

   task automatic drive(int pct);
      logic keep;
      for (int i = 0; i < US; i++) begin
         keep = bus.ivalid[i] && !acc[i];
         if (pend[i].size() > 0 && (keep || $urandom_range(1, 100) <= pct)) begin
            bus.ivalid[i] = 1'b1;
            bus.idata[i] = pend[i][0][DW-1:0];
            bus.ilast[i] = pend[i][0][DW];
         end else bus.ivalid[i] = 1'b0;
      end
   endtask

   task automatic step(logic [US-1:0] r);
      int c;
      logic newpkt;
      c = -1;
      newpkt = (m_owner < 0);
      for (int i = 0; i < US; i++) begin
         acc[i] = 1'b0;
         if (r[i] && bus.ivalid[i]) c = i;
      end
      for (int i = 0; i < US; i++)
         if (!bus.ivalid[i]) wt[i] = 0;
         else if (c >= 0 && i != c && newpkt) wt[i]++;
      if (c >= 0) begin
         acc[c] = 1'b1;
         if (newpkt) begin
            chk("fair_wait", 32'(wt[c] < US), 1);
            wt[c] = 0;
         end
         m_ov = 1'b1;
         m_data = bus.idata[c];
         m_last = bus.ilast[c];
         m_id = c;
         if (bus.ilast[c]) begin
            m_owner = -1;
            m_ptr = (c + 1) % US;
         end else m_owner = c;
         if (pend[c].size() > 0) void'(pend[c].pop_front());
      end else if (bus.oready) m_ov = 1'b0;
   endtask

   task automatic outbeat();
      int id;
      id = int'(bus.oid);
      olog.push_back((int'(bus.olast) << 20) | (id << 16) | int'($unsigned(bus.odata)));
      if (out_mid) chk("no_interleave", id, out_id);
      out_mid = !bus.olast;
      out_id = id;
      if (sent[id].size() == 0) begin
         n_cmp++;
         n_bad++;
         $display("FAIL sb_extra: got beat %0h on channel %0d, required none", bus.odata, id);
      end else chk("sb_order", {bus.olast, bus.odata}, sent[id].pop_front());
   endtask

   task automatic cyc(int pct, logic ordy);
      logic [US-1:0] r;
      bus.oready = ordy;
      drive(pct);
      #1;
      r = exp_rdy();
      chk("iready", bus.iready, r);
      if (bus.ovalid && bus.oready) outbeat();
      step(r);
      @(negedge clk);
      chk("ovalid", bus.ovalid, m_ov);
      if (m_ov) begin
         chk("odata", $unsigned(bus.odata), m_data);
         chk("olast", bus.olast, m_last);
         chk("oid", bus.oid, m_id);
      end
   endtask

   task automatic do_reset();
      rst = 1'b0;
      bus.oready = 1'b0;
      bus.ilast = '0;
      bus.ivalid = '1;
      acc = '0;
      for (int i = 0; i < US; i++) begin
         bus.idata[i] = '0;
         pend[i].delete();
         sent[i].delete();
         wt[i] = 0;
      end
      olog.delete();
      m_ov = 1'b0;
      m_last = 1'b0;
      m_data = '0;
      m_id = 0;
      m_owner = -1;
      m_ptr = 0;
      out_mid = 1'b0;
      out_id = 0;
      repeat (2) @(negedge clk);
      chk("rst_ovalid", bus.ovalid, 0);
      chk("rst_odata", $unsigned(bus.odata), 0);
      chk("rst_olast", bus.olast, 0);
      chk("rst_oid", bus.oid, 0);
      chk("rst_iready", bus.iready, 0);
      bus.ivalid = '0;
      rst = 1'b1;
   endtask

   task automatic gen();
      int len;
      for (int i = 0; i < US; i++)
         if (pend[i].size() == 0 && $urandom_range(0, 7) == 0) begin
            len = $urandom_range(1, 8);
            for (int b = 0; b < len; b++) begin
               push(i, DW'(i * 4096 + seq[i] % 4096), b == len - 1);
               seq[i]++;
            end
         end
   endtask

   initial begin
      int left;
      for (int i = 0; i < US; i++) seq[i] = 0;
      // single 3-beat packet on ch0, then ch1 must win the next contest
      do_reset();
      push(0, 16'h11, 1'b0);
      push(0, 16'h12, 1'b0);
      push(0, 16'h13, 1'b1);
      cyc(100, 1'b1);
      chk("t1_latency", $unsigned(bus.odata), 16'h11);
      repeat (3) cyc(100, 1'b1);
      chk("t1_count", olog.size(), 3);
      exp_log("t1_b0", 0, 'h00011);
      exp_log("t1_b1", 1, 'h00012);
      exp_log("t1_b2", 2, 'h100013);
      push(0, 16'hA0, 1'b1);
      push(1, 16'hB0, 1'b1);
      repeat (3) cyc(100, 1'b1);
      exp_log("t1_ptr_first", 3, 'h1100B0);
      exp_log("t1_ptr_second", 4, 'h1000A0);
      // two always-valid channels with 2-beat packets alternate without gaps
      do_reset();
      for (int p = 0; p < 3; p++) begin
         push(0, DW'('h30 + 2 * p), 1'b0);
         push(0, DW'('h31 + 2 * p), 1'b1);
         push(1, DW'('h40 + 2 * p), 1'b0);
         push(1, DW'('h41 + 2 * p), 1'b1);
      end
      repeat (13) cyc(100, 1'b1);
      chk("t2_count", olog.size(), 12);
      for (int k = 0; k < olog.size(); k++) chk("t2_id", (olog[k] >> 16) & 15, (k / 2) % 2);
      // backpressure in the middle of a ch1 packet
      do_reset();
      push(1, 16'h21, 1'b0);
      push(1, 16'h22, 1'b0);
      push(1, 16'h23, 1'b0);
      push(1, 16'h24, 1'b1);
      repeat (2) cyc(100, 1'b1);
      repeat (3) begin
         cyc(100, 1'b0);
         chk("t3_hold", $unsigned(bus.odata), 16'h22);
         chk("t3_stall_rdy", bus.iready, 0);
      end
      repeat (4) cyc(100, 1'b1);
      chk("t3_count", olog.size(), 4);
      exp_log("t3_b0", 0, 'h10021);
      exp_log("t3_b1", 1, 'h10022);
      exp_log("t3_b2", 2, 'h10023);
      exp_log("t3_b3", 3, 'h110024);
      // single-beat packets on all four channels rotate every cycle
      do_reset();
      for (int rep = 0; rep < 2; rep++)
         for (int ch = 0; ch < US; ch++) push(ch, DW'('h50 + ch + 4 * rep), 1'b1);
      repeat (9) cyc(100, 1'b1);
      chk("t4_count", olog.size(), 8);
      for (int k = 0; k < olog.size(); k++) chk("t4_id", (olog[k] >> 16) & 15, k % 4);
      // asynchronous reset mid-packet, arbitration restarts at ch0
      do_reset();
      push(0, 16'h41, 1'b0);
      push(0, 16'h42, 1'b0);
      push(0, 16'h43, 1'b0);
      push(0, 16'h44, 1'b1);
      repeat (2) cyc(100, 1'b1);
      chk("t5_pre_ovalid", bus.ovalid, 1);
      #2 rst = 1'b0;
      #1;
      chk("t5_async_ovalid", bus.ovalid, 0);
      chk("t5_async_iready", bus.iready, 0);
      do_reset();
      push(1, 16'h51, 1'b1);
      push(0, 16'h61, 1'b1);
      repeat (3) cyc(100, 1'b1);
      exp_log("t5_first", 0, 'h100061);
      exp_log("t5_second", 1, 'h110051);
      // randomized traffic, then drain everything that was sent
      do_reset();
      for (int n = 0; n < 10000; n++) begin
         gen();
         cyc($urandom_range(20, 100), $urandom_range(0, 3) != 0);
      end
      left = 0;
      for (int n = 0; n < 3000; n++) begin
         left = 0;
         for (int i = 0; i < US; i++) left += sent[i].size();
         if (left == 0) break;
         cyc(100, 1'b1);
      end
      left = 0;
      for (int i = 0; i < US; i++) left += sent[i].size();
      chk("drain_left", left, 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/str_rr_merge.md
STR_RR_MERGE -- requirements
Module: str_rr_merge

Interface
REQ-001 Parameter US, default 2: number of upstream streams merged; legal range 2..16.
REQ-002 Parameter DW, default 16: data width.
REQ-003 Localparam IW SHALL equal $clog2(US): width of the channel id.
REQ-004 clk  input  1  single clock; all logic SHALL be on its rising edge.
REQ-005 rst  input  1  reset; asynchronous, active-low (asserted at 0).
REQ-006 idata  input  signed [DW-1:0] x US (unpacked)  upstream data.
REQ-007 ilast  input  1 x US  upstream end-of-packet flag.
REQ-008 ivalid  input  1 x US  upstream valid.
REQ-009 iready  output  1 x US  upstream ready.
REQ-010 odata  output  signed [DW-1:0]  merged data.
REQ-011 oid  output  [IW-1:0]  index of the upstream that supplied the current beat.
REQ-012 olast  output  1  merged end-of-packet flag.
REQ-013 ovalid  output  1  merged valid.
REQ-014 oready  input  1  downstream ready.

Function
REQ-015 A transfer SHALL occur on any port where valid and ready are both 1 at a rising edge.
REQ-016 The block SHALL be packet-atomic: once a packet's first beat is accepted from upstream g, no beat from any other upstream SHALL be accepted until the beat with ilast[g]=1 from g has been accepted.
REQ-017 The block SHALL have two states: IDLE (no grant held) and LOCK (grant held on channel g).
REQ-018 In IDLE, sel SHALL be the first i with ivalid[i]=1 when searching i = ptr, ptr+1, ..., wrapping modulo US. sel SHALL be combinational.
REQ-019 The output stage SHALL be a single forward register: ofree = ~ovalid | oready.
REQ-020 In IDLE, iready[sel] SHALL equal ofree and every other iready SHALL be 0. With no ivalid set, all iready SHALL be 0.
REQ-021 In LOCK, iready[g] SHALL equal ofree and every other iready SHALL be 0, regardless of the other ivalid bits.
REQ-022 No iready SHALL depend on oready other than through ofree. ivalid SHALL NOT depend on iready.
REQ-023 On a transfer from upstream i, odata, olast and oid SHALL load idata[i], ilast[i] and i, and ovalid SHALL be set on the next edge. Latency is 1 cycle.
REQ-024 If no upstream transfer occurs and oready=1, ovalid SHALL clear. Otherwise odata, olast, oid and ovalid SHALL hold.
REQ-025 IDLE to LOCK: the accepted beat has ilast=0; g SHALL be set to sel.
REQ-026 LOCK to IDLE: the accepted beat from g has ilast=1.
REQ-027 Whenever a beat with ilast=1 is accepted from upstream i, ptr SHALL become (i+1) mod US. This includes a single-beat packet accepted in IDLE.
REQ-028 Throughput SHALL be one beat per cycle, with zero bubbles between back-to-back packets, including packets from different upstreams.
REQ-029 While oready=0 and ovalid=1, all iready SHALL be 0, and state, g and ptr SHALL hold.

Reset
REQ-030 On rst=0, the block SHALL asynchronously set ovalid=0, olast=0, odata=0, oid=0, state=IDLE, ptr=0 and g=0.
REQ-031 Reset mid-packet SHALL discard the in-flight packet and held beat. After release, arbitration SHALL restart from ptr=0.
REQ-032 All iready SHALL be 0 while rst=0.

Verification
REQ-033 Single source: US=2, ch0 sends 3-beat packet 0x11,0x12,0x13 (last on 0x13), oready=1 -> odata 0x11,0x12,0x13 in consecutive cycles starting 1 cycle after first accept; oid=0; olast only on 0x13; ptr=1 afterwards.
REQ-034 Contention/lock: ch0 and ch1 both continuously valid, 2-beat packets each, oready=1 -> output ch0 packet, then ch1 packet, then ch0, alternating with no gaps; oid never changes mid-packet.
REQ-035 Backpressure: during ch1 packet 0x21..0x24, oready=0 for 3 cycles at beat 2 -> odata holds 0x22, all iready=0 for those cycles, no beat lost or duplicated, order preserved.
REQ-036 Single-beat packets: US=4, all four valid with ilast=1, oready=1 -> oid sequence 0,1,2,3,0,... one per cycle.
REQ-037 Reset mid-packet: assert rst=0 after 2 of 4 beats of ch0 -> ovalid drops immediately (asynchronously). After release with ch1 and ch0 valid, ch0 is granted first (ptr=0).
REQ-038 Random bench: random ivalid, packet lengths 1..8 and oready over 10k cycles -> scoreboard per channel shows in-order, lossless delivery; no interleaving inside any packet; every waiting channel is served within US packets.
